// File: rtl/sched_pkg.sv
// sched_pkg: shared types, defaults and helpers for tick_timer_scheduler.
// Holds the channel state encoding and the prescaler width helper.
`default_nettype none
package sched_pkg;

    localparam int unsigned CLK_HZ_DEFAULT  = 72000000;
    localparam int unsigned TICK_HZ_DEFAULT = 1;

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Prescaler counter width for a CLK_HZ -> TICK_HZ division (DIV >= 2).
    function automatic int unsigned clog2_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return $clog2(clk_hz / tick_hz);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clock by DIV = CLK_HZ/TICK_HZ into a registered 1-cycle tick.
// strobe_o is the unregistered wrap condition, i.e. the cycle in which tick is being set.
`default_nettype none
module tick_prescaler
    import sched_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ = TICK_HZ_DEFAULT
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic strobe_o,
    output logic tick_o
);
    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = clog2_div(CLK_HZ, TICK_HZ);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    assign strobe_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            cnt_d = strobe_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= strobe_o;
        end
    end

    assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/tick_timer_scheduler.sv
// tick_timer_scheduler: N_CH countdown timers on one shared timebase, loaded via a round-robin req/ack arbiter.
// Define SCHED_AUTO_RELOAD_EN to add the periodic input and per-channel auto-reload.
`default_nettype none
module tick_timer_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ = TICK_HZ_DEFAULT,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned SEC_W   = 8
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [N_CH-1:0]         req_i,
    input  logic [N_CH*SEC_W-1:0]   load_sec_i,
    input  logic [N_CH-1:0]         cancel_i,
`ifdef SCHED_AUTO_RELOAD_EN
    input  logic [N_CH-1:0]         periodic_i,
`endif
    output logic [N_CH-1:0]         ack_o,
    output logic [N_CH-1:0]         busy_o,
    output logic [N_CH-1:0]         done_o,
    output logic                    tick_o
);
    localparam int unsigned PTR_W = $clog2(N_CH);
    localparam int          NCH_I = int'(N_CH);

    logic             strobe;
    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  ack_q, ack_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .strobe_o (strobe),
        .tick_o   (tick_o)
    );

    // A channel whose ack is already out is masked so a late-dropping req cannot double-load.
    assign eligible = req_i & ~cancel_i & ~ack_q;

    always_comb begin
        ack_d = '0;
        ptr_d = ptr_q;
        for (int k = 0; k < NCH_I; k++) begin
            if ((ack_d == '0) && eligible[(int'(ptr_q) + k) % NCH_I]) begin
                ack_d[(int'(ptr_q) + k) % NCH_I] = 1'b1;
                ptr_d = PTR_W'((int'(ptr_q) + k + 1) % NCH_I);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ack_q <= '0;
            ptr_q <= '0;
        end else begin
            ack_q <= ack_d;
            ptr_q <= ptr_d;
        end
    end

    assign ack_o = ack_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_e        state_q, state_d;
        logic [SEC_W-1:0] cnt_q, cnt_d, load_w;
        logic             done_q, done_d;
`ifdef SCHED_AUTO_RELOAD_EN
        logic [SEC_W-1:0] reload_q, reload_d;
`endif

        assign load_w = load_sec_i[i*SEC_W +: SEC_W];

        // Priority: cancel, then load, then tick; a load in a tick cycle swallows that tick.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            done_d  = 1'b0;
`ifdef SCHED_AUTO_RELOAD_EN
            reload_d = reload_q;
`endif
            if (cancel_i[i]) begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end else if (ack_d[i]) begin
`ifdef SCHED_AUTO_RELOAD_EN
                reload_d = load_w;
`endif
                if (load_w != '0) begin
                    state_d = CH_RUN;
                    cnt_d   = load_w;
                end else begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end else if (strobe && (state_q == CH_RUN)) begin
                if (cnt_q == SEC_W'(1)) begin
                    done_d = 1'b1;
`ifdef SCHED_AUTO_RELOAD_EN
                    if (periodic_i[i]) begin
                        cnt_d = reload_q;
                    end else begin
                        state_d = CH_IDLE;
                        cnt_d   = '0;
                    end
`else
                    state_d = CH_IDLE;
                    cnt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q - SEC_W'(1);
                end
            end
        end

        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                state_q <= CH_IDLE;
                cnt_q   <= '0;
                done_q  <= 1'b0;
`ifdef SCHED_AUTO_RELOAD_EN
                reload_q <= '0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                done_q  <= done_d;
`ifdef SCHED_AUTO_RELOAD_EN
                reload_q <= reload_d;
`endif
            end
        end

        assign busy_o[i] = (state_q == CH_RUN);
        assign done_o[i] = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_timer_scheduler.sv
// tb_tick_timer_scheduler: directed vector table plus multi-cycle sequences for tick_timer_scheduler.
// Runs with CLK_HZ=8, TICK_HZ=1 (DIV=8), N_CH=4, SEC_W=8.
`default_nettype none
module tb_tick_timer_scheduler;

    localparam int DIV = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [31:0] load_sec;
    logic [3:0]  cancel;
    logic [3:0]  periodic;
    logic [3:0]  ack, busy, done;
    logic        tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    tick_timer_scheduler #(
        .CLK_HZ  (8),
        .TICK_HZ (1),
        .N_CH    (4),
        .SEC_W   (8)
    ) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .enable_i   (enable),
        .req_i      (req),
        .load_sec_i (load_sec),
        .cancel_i   (cancel),
`ifdef SCHED_AUTO_RELOAD_EN
        .periodic_i (periodic),
`endif
        .ack_o      (ack),
        .busy_o     (busy),
        .done_o     (done),
        .tick_o     (tick)
    );

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic [3:0]  cancel;
        logic [31:0] load;
        logic [3:0]  ack;
        logic [3:0]  busy;
        logic [3:0]  done;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Holds reset over two edges, checks the cleared outputs, then releases just after an edge.
    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b1;
        req      = '0;
        cancel   = '0;
        periodic = '0;
        load_sec = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset ack",  {28'd0, ack},  32'd0);
        chk("reset busy", {28'd0, busy}, 32'd0);
        chk("reset done", {28'd0, done}, 32'd0);
        chk("reset tick", {31'd0, tick}, 32'd0);
        reset = 1'b0;
    endtask

    // Called in the ack cycle of a ch0 one-shot load; returns cycles to done0 and ticks seen by then.
    task automatic run_expiry(input int pause_at, input int pause_len, output int delay, output int ticks);
        int  cyc;
        int  pause_ticks;
        int  early_drop;
        bit  seen;
        cyc = 0; ticks = 0; delay = -1; seen = 0; pause_ticks = 0; early_drop = 0;
        while (!seen && cyc < 100) begin
            if (pause_len > 0 && cyc == pause_at) enable = 1'b0;
            if (pause_len > 0 && cyc == pause_at + pause_len) enable = 1'b1;
            step();
            cyc++;
            if (tick) ticks++;
            if (!enable && tick) pause_ticks++;
            if (done[0]) begin
                seen  = 1;
                delay = cyc;
                chk("busy0 falls with done0", {31'd0, busy[0]}, 32'd0);
                chk("done0 with tick", {31'd0, tick}, 32'd1);
            end else if (!busy[0]) begin
                early_drop++;
            end
        end
        enable = 1'b1;
        chk("expiry seen before timeout", {31'd0, seen}, 32'd1);
        chk("busy0 held until expiry", early_drop, 32'd0);
        chk("no tick while disabled", pause_ticks, 32'd0);
        step();
        chk("done0 single pulse", {31'd0, done[0]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin : main
        int d1, t1, d2, t2, cnt, busy_drop;
        int dt [3];
        int nd;

        // Arbiter and channel control with enable=0, so no tick ever disturbs the counts.
        vt[0]  = '{1'b0, 4'b1111, 4'b0000, 32'h02020202, 4'b0001, 4'b0001, 4'b0000};
        vt[1]  = '{1'b0, 4'b1110, 4'b0000, 32'h02020202, 4'b0010, 4'b0011, 4'b0000};
        vt[2]  = '{1'b0, 4'b1100, 4'b0000, 32'h02020202, 4'b0100, 4'b0111, 4'b0000};
        vt[3]  = '{1'b0, 4'b1000, 4'b0000, 32'h02020202, 4'b1000, 4'b1111, 4'b0000};
        vt[4]  = '{1'b0, 4'b0000, 4'b0000, 32'h02020202, 4'b0000, 4'b1111, 4'b0000};
        vt[5]  = '{1'b0, 4'b0100, 4'b0000, 32'h02000202, 4'b0100, 4'b1011, 4'b0100};
        vt[6]  = '{1'b0, 4'b0000, 4'b0000, 32'h02020202, 4'b0000, 4'b1011, 4'b0000};
        vt[7]  = '{1'b0, 4'b0000, 4'b0010, 32'h02020202, 4'b0000, 4'b1001, 4'b0000};
        vt[8]  = '{1'b0, 4'b0001, 4'b0001, 32'h02020202, 4'b0000, 4'b1000, 4'b0000};
        vt[9]  = '{1'b0, 4'b0001, 4'b0000, 32'h02020202, 4'b0001, 4'b1001, 4'b0000};
        vt[10] = '{1'b0, 4'b0000, 4'b0000, 32'h02020202, 4'b0000, 4'b1001, 4'b0000};
        vt[11] = '{1'b0, 4'b1001, 4'b0000, 32'h02020202, 4'b1000, 4'b1001, 4'b0000};
        vt[12] = '{1'b0, 4'b0001, 4'b0000, 32'h02020202, 4'b0001, 4'b1001, 4'b0000};
        vt[13] = '{1'b0, 4'b0001, 4'b0000, 32'h02020202, 4'b0000, 4'b1001, 4'b0000};
        vt[14] = '{1'b0, 4'b0001, 4'b0000, 32'h02020202, 4'b0001, 4'b1001, 4'b0000};
        vt[15] = '{1'b0, 4'b0000, 4'b0000, 32'h02020202, 4'b0000, 4'b1001, 4'b0000};
        vt[16] = '{1'b0, 4'b0000, 4'b1111, 32'h02020202, 4'b0000, 4'b0000, 4'b0000};
        vt[17] = '{1'b0, 4'b0101, 4'b0100, 32'h02020202, 4'b0001, 4'b0001, 4'b0000};
        vt[18] = '{1'b0, 4'b0000, 4'b0000, 32'h02020202, 4'b0000, 4'b0001, 4'b0000};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            enable   = vt[i].en;
            req      = vt[i].req;
            cancel   = vt[i].cancel;
            load_sec = vt[i].load;
            step();
            chk($sformatf("vec%0d ack", i),  {28'd0, ack},  {28'd0, vt[i].ack});
            chk($sformatf("vec%0d busy", i), {28'd0, busy}, {28'd0, vt[i].busy});
            chk($sformatf("vec%0d done", i), {28'd0, done}, {28'd0, vt[i].done});
            chk($sformatf("vec%0d tick", i), {31'd0, tick}, 32'd0);
        end

        // One-shot load of 3 on ch0: done with the third tick, within one tick period of 3*DIV.
        do_reset();
        load_sec = 32'h00000003;
        req      = 4'b0001;
        step();
        chk("A ack0", {28'd0, ack}, 32'h1);
        chk("A busy0", {31'd0, busy[0]}, 32'd1);
        req = '0;
        run_expiry(0, 0, d1, t1);
        chk("A ticks at done", t1, 32'd3);
        chk("A delay in range", {31'd0, (d1 >= 2*DIV+1) && (d1 <= 3*DIV)}, 32'd1);

        // Same run with a 20-cycle enable gap: expiry shifts by exactly 20.
        do_reset();
        load_sec = 32'h00000003;
        req      = 4'b0001;
        step();
        chk("B ack0", {28'd0, ack}, 32'h1);
        req = '0;
        run_expiry(5, 20, d2, t2);
        chk("B ticks at done", t2, 32'd3);
        chk("B delay shift", d2, d1 + 20);

        // Cancel landing on the very tick that would expire ch1.
        do_reset();
        load_sec = 32'h00000100;
        req      = 4'b0010;
        step();
        chk("C ack1", {28'd0, ack}, 32'h2);
        req = '0;
        repeat (DIV - 2) step();
        chk("C busy1 before cancel", {31'd0, busy[1]}, 32'd1);
        cancel = 4'b0010;
        step();
        cancel = '0;
        chk("C tick coincident", {31'd0, tick}, 32'd1);
        chk("C busy1 cleared", {31'd0, busy[1]}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (done[1]) cnt++;
            step();
        end
        chk("C no done1", cnt, 32'd0);

        // Asynchronous reset mid-cycle with three channels counting and ack2 out.
        do_reset();
        load_sec = 32'h00050505;
        req = 4'b0111; step();
        req = 4'b0110; step();
        req = 4'b0100; step();
        req = 4'b0000;
        chk("D ack2 before reset", {28'd0, ack}, 32'h4);
        chk("D busy before reset", {28'd0, busy}, 32'h7);
        #2;
        reset = 1'b1;
        #1;
        chk("D async ack",  {28'd0, ack},  32'd0);
        chk("D async busy", {28'd0, busy}, 32'd0);
        chk("D async done", {28'd0, done}, 32'd0);
        chk("D async tick", {31'd0, tick}, 32'd0);
        step();
        reset = 1'b0;

`ifdef SCHED_AUTO_RELOAD_EN
        // Periodic ch0 with load 2: done every 2*DIV cycles, busy held, stopped only by cancel.
        do_reset();
        periodic = 4'b0001;
        load_sec = 32'h00000002;
        req      = 4'b0001;
        step();
        req = '0;
        nd = 0; busy_drop = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (done[0] && nd < 3) begin
                dt[nd] = i;
                nd++;
            end
            if (!busy[0]) busy_drop++;
        end
        chk("E three dones", nd, 32'd3);
        if (nd == 3) begin
            chk("E period 1", dt[1] - dt[0], 2 * DIV);
            chk("E period 2", dt[2] - dt[1], 2 * DIV);
        end
        chk("E busy held", busy_drop, 32'd0);
        cancel = 4'b0001;
        step();
        cancel = '0;
        chk("E cancel busy0", {31'd0, busy[0]}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 5 * DIV; i++) begin
            step();
            if (done[0]) cnt++;
        end
        chk("E no done after cancel", cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
